// File: rtl/des_pkg.sv
// DES tables, FSM states and permutation helpers shared by the sequencer.
// Bit numbering is MSB-first: DES bit k lives at vector index width-k.
package des_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    DONE
  } state_t;

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  localparam int FP_T [64] = '{
    40,  8, 48, 16, 56, 24, 64, 32,
    39,  7, 47, 15, 55, 23, 63, 31,
    38,  6, 46, 14, 54, 22, 62, 30,
    37,  5, 45, 13, 53, 21, 61, 29,
    36,  4, 44, 12, 52, 20, 60, 28,
    35,  3, 43, 11, 51, 19, 59, 27,
    34,  2, 42, 10, 50, 18, 58, 26,
    33,  1, 41,  9, 49, 17, 57, 25
  };

  localparam logic [1:0] SHIFT_T [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2,
    2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic logic [55:0] pc1(
    input logic [63:0] k
  );
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++)
      r[6'(55 - i)] = k[6'(64 - PC1_T[i])];
    return r;
  endfunction

  function automatic logic [47:0] pc2(
    input logic [55:0] cd
  );
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++)
      r[6'(47 - i)] = cd[6'(56 - PC2_T[i])];
    return r;
  endfunction

  function automatic logic [63:0] fp(
    input logic [63:0] b
  );
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++)
      r[6'(63 - i)] = b[6'(64 - FP_T[i])];
    return r;
  endfunction

  function automatic logic [27:0] rol28(
    input logic [27:0] x,
    input logic [1:0]  n
  );
    return (n == 2'd2) ? {x[25:0], x[27:26]}
                       : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] ror28(
    input logic [27:0] x,
    input logic [1:0]  n
  );
    return (n == 2'd2) ? {x[1:0], x[27:2]}
                       : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_ip.sv
// DES initial permutation, purely combinational.
// MSB-first numbering: DES bit k is vector index 64-k.
module des_ip (
  input  logic [63:0] i_data,
  output logic [63:0] o_data
);

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10,  2,
    60, 52, 44, 36, 28, 20, 12,  4,
    62, 54, 46, 38, 30, 22, 14,  6,
    64, 56, 48, 40, 32, 24, 16,  8,
    57, 49, 41, 33, 25, 17,  9,  1,
    59, 51, 43, 35, 27, 19, 11,  3,
    61, 53, 45, 37, 29, 21, 13,  5,
    63, 55, 47, 39, 31, 23, 15,  7
  };

  always_comb begin
    o_data = '0;
    for (int i = 0; i < 64; i++)
      o_data[6'(63 - i)] = i_data[6'(64 - IP_T[i])];
  end

endmodule

// File: rtl/des_key_schedule.sv
// On-the-fly DES subkey generator: C/D halves, direction and rotation.
// Decrypt starts from C0D0 (== C16D16) and rotates right after each use.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_step,
  input  logic [63:0] i_key,
  input  logic        i_decrypt,
  input  logic [3:0]  i_round_idx,
  output logic [47:0] o_key
);

  logic [27:0] r_c;
  logic [27:0] r_d;
  logic        r_mode;

  logic [55:0] w_pc1;
  logic [1:0]  w_sh_enc;
  logic [1:0]  w_sh_dec;
  logic [27:0] w_c_enc;
  logic [27:0] w_d_enc;
  logic [27:0] w_c_nxt;
  logic [27:0] w_d_nxt;

  assign w_pc1    = pc1(i_key);
  assign w_sh_enc = SHIFT_T[i_round_idx];
  assign w_sh_dec = SHIFT_T[4'd15 - i_round_idx];
  assign w_c_enc  = rol28(r_c, w_sh_enc);
  assign w_d_enc  = rol28(r_d, w_sh_enc);

  assign w_c_nxt = r_mode ? ror28(r_c, w_sh_dec)
                          : w_c_enc;
  assign w_d_nxt = r_mode ? ror28(r_d, w_sh_dec)
                          : w_d_enc;

  assign o_key = r_mode ? pc2({r_c, r_d})
                        : pc2({w_c_enc, w_d_enc});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c    <= '0;
      r_d    <= '0;
      r_mode <= 1'b0;
    end else if (i_load) begin
      r_c    <= w_pc1[55:28];
      r_d    <= w_pc1[27:0];
      r_mode <= i_decrypt;
    end else if (i_step) begin
      r_c    <= w_c_nxt;
      r_d    <= w_d_nxt;
    end
  end

endmodule

// File: rtl/des_round_sequencer.sv
// Iterative DES controller: IP on accept, one Feistel round per clock
// against an external f datapath, FP into a held output register.
module des_round_sequencer
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_block,
  input  logic [63:0] in_key,
  input  logic        in_decrypt,
  output logic [31:0] f_r,
  output logic [47:0] f_key,
  input  logic [31:0] f_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_block,
  output logic        busy,
  output logic [3:0]  round_idx
);

  localparam logic [3:0] LAST = 4'(ROUNDS - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_l;
  logic [31:0] r_r;
  logic [63:0] r_out;
  logic [3:0]  r_round_idx;

  logic        w_accept;
  logic        w_step;
  logic        w_last;
  logic [63:0] w_ip;
  logic [31:0] w_r_nxt;

  assign w_accept = in_valid && (r_state == IDLE);
  assign w_step   = (r_state == ROUND);
  assign w_last   = (r_round_idx == LAST);
  assign w_r_nxt  = r_l ^ f_result;

  des_ip u_ip (
    .i_data (in_block),
    .o_data (w_ip)
  );

  des_key_schedule u_ks (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_load      (w_accept),
    .i_step      (w_step),
    .i_key       (in_key),
    .i_decrypt   (in_decrypt),
    .i_round_idx (r_round_idx),
    .o_key       (f_key)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept)  w_state_nxt = ROUND;
      ROUND:   if (w_last)    w_state_nxt = DONE;
      DONE:    if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
    busy      = (r_state == ROUND)
             || (r_state == DONE);
  end

  // Last round emits the swapped pre-output {R16, L16} through FP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_l         <= '0;
      r_r         <= '0;
      r_out       <= '0;
      r_round_idx <= '0;
    end else begin
      unique case (1'b1)
        w_accept: begin
          r_l         <= w_ip[63:32];
          r_r         <= w_ip[31:0];
          r_round_idx <= '0;
        end
        w_step: begin
          r_l <= r_r;
          r_r <= w_r_nxt;
          if (w_last) begin
            r_out       <= fp({w_r_nxt, r_r});
            r_round_idx <= '0;
          end else begin
            r_round_idx <= r_round_idx + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign f_r       = r_r;
  assign out_block = r_out;
  assign round_idx = r_round_idx;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Directed bench: known DES vectors, latency, back-pressure, mid-run reset.
// Holds its own f (E, S-boxes, P) to close the loop with the sequencer.
module tb_des_round_sequencer;

  localparam int unsigned NR = 16;

  localparam logic [63:0] K1 = 64'h133457799BBCDFF1;
  localparam logic [63:0] P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] C1 = 64'h85E813540F0AB405;
  localparam logic [63:0] K2 = 64'h0E329232EA6D0D73;
  localparam logic [63:0] K2P = 64'h0F339333EB6C0C72;
  localparam logic [63:0] P2 = 64'h8787878787878787;
  localparam logic [63:0] C2 = 64'h0000000000000000;

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,
     4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13,
    12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21,
    20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29,
    28, 29, 30, 31, 32,  1
  };

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,
     1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9,
    19, 13, 30,  6, 22, 11,  4, 25
  };

  localparam int SB [512] = '{
    14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
     0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
     4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
    15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
    15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
     3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
     0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
    13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
    10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
    13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
    13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
     1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
     7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
    13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
    10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
     3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
     2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
    14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
     4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
    11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
    12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
    10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
     9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
     4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
     4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
    13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
     1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
     6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
    13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
     1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
     7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
     2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
  };

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_block = '0;
  logic [63:0] in_key = '0;
  logic        in_decrypt = 1'b0;
  logic [31:0] f_r;
  logic [47:0] f_key;
  logic [31:0] f_result;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] out_block;
  logic        busy;
  logic [3:0]  round_idx;

  int n_cmp = 0;
  int n_bad = 0;

  des_round_sequencer #(.ROUNDS(NR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_block   (in_block),
    .in_key     (in_key),
    .in_decrypt (in_decrypt),
    .f_r        (f_r),
    .f_key      (f_key),
    .f_result   (f_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_block  (out_block),
    .busy       (busy),
    .round_idx  (round_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] des_f(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0] e;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    int          idx;
    e = '0;
    s = '0;
    p = '0;
    for (int i = 0; i < 48; i++)
      e[6'(47 - i)] = r[5'(32 - E_T[i])];
    e = e ^ k;
    for (int j = 0; j < 8; j++) begin
      b = 6'(e >> (42 - 6 * j));
      idx = j * 64 + int'({b[5], b[0]}) * 16
          + int'(b[4:1]);
      s = {s[27:0], 4'(SB[idx])};
    end
    for (int i = 0; i < 32; i++)
      p[5'(31 - i)] = s[5'(32 - P_T[i])];
    return p;
  endfunction

  always_comb f_result = des_f(f_r, f_key);

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  // Present one block for a single accepting edge, then scramble inputs.
  task automatic send(
    input logic [63:0] key,
    input logic [63:0] blk,
    input logic        dec
  );
    @(negedge clk);
    assert (!(dec && NR != 16))
      else $fatal(1, "FAIL dec_rounds: decrypt needs 16 rounds");
    in_key     = key;
    in_block   = blk;
    in_decrypt = dec;
    in_valid   = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    in_key     = ~key;
    in_block   = ~blk;
    in_decrypt = ~dec;
  endtask

  task automatic rounds(
    input string       tag,
    input logic        chk_k1,
    input logic [47:0] k1
  );
    for (int k = 0; k < 16; k++) begin
      check({tag, "_idx"}, 64'(round_idx), 64'(k));
      check({tag, "_ov0"}, 64'(out_valid), 64'd0);
      if (k == 0 && chk_k1)
        check({tag, "_k1"}, 64'(f_key), 64'(k1));
      @(negedge clk);
    end
    check({tag, "_ov1"}, 64'(out_valid), 64'd1);
  endtask

  task automatic take(
    input string       tag,
    input logic [63:0] exp
  );
    check({tag, "_out"}, out_block, exp);
    check({tag, "_busy"}, 64'(busy), 64'd1);
    check({tag, "_rdy0"}, 64'(in_ready), 64'd0);
    @(negedge clk);
    check({tag, "_rdy1"}, 64'(in_ready), 64'd1);
    check({tag, "_ovx"}, 64'(out_valid), 64'd0);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    int seen;
    @(negedge clk);
    check("rst_rdy", 64'(in_ready), 64'd1);
    check("rst_ov", 64'(out_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_idx", 64'(round_idx), 64'd0);
    check("rst_out", out_block, 64'd0);
    rst_n = 1'b1;

    send(K1, P1, 1'b0);
    rounds("enc1", 1'b1, 48'h1B02EFFC7072);
    take("enc1", C1);

    send(K1, C1, 1'b1);
    rounds("dec1", 1'b1, 48'hCB3D8B0E17F5);
    take("dec1", P1);

    send(K2, P2, 1'b0);
    rounds("enc2", 1'b0, '0);
    take("enc2", C2);

    send(K2P, P2, 1'b0);
    rounds("par", 1'b0, '0);
    take("par", C2);

    out_ready = 1'b0;
    send(K1, P1, 1'b0);
    rounds("bp1", 1'b0, '0);
    in_key     = K2;
    in_block   = P2;
    in_decrypt = 1'b0;
    in_valid   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      check("bp_hold", out_block, C1);
      check("bp_rdy", 64'(in_ready), 64'd0);
      check("bp_ov", 64'(out_valid), 64'd1);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_rdy1", 64'(in_ready), 64'd1);
    check("bp_ov0", 64'(out_valid), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rounds("bp2", 1'b0, '0);
    take("bp2", C2);

    send(K1, P1, 1'b0);
    repeat (7) @(negedge clk);
    check("rr_idx7", 64'(round_idx), 64'd7);
    rst_n = 1'b0;
    #1;
    check("rr_rdy", 64'(in_ready), 64'd1);
    check("rr_busy", 64'(busy), 64'd0);
    check("rr_ov", 64'(out_valid), 64'd0);
    check("rr_idx", 64'(round_idx), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      @(negedge clk);
    end
    check("rr_nopulse", 64'(seen), 64'd0);
    send(K1, P1, 1'b0);
    rounds("rr2", 1'b1, 48'h1B02EFFC7072);
    take("rr2", C1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
